flag_bank: RTL
==============

FLAG_BANK -- requirements
Module: flag_bank

Interface
REQ-001 SHALL have parameter NFLAGS, default 4: number of single-bit flags (E, S, IEN, R, ...); legal range 1..16.
REQ-002 SHALL have parameter DEPTH, default 2: flag-stack entries; legal range 1..8.
REQ-003 SHALL have parameter RST_VAL, default all-zero, NFLAGS bits: per-flag reset value.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port op_valid, input, 1 bit: command strobe.
REQ-007 SHALL have port op_sel, input, $clog2(NFLAGS) bits (minimum 1): target flag index.
REQ-008 SHALL have port op_code, input, 3 bits: 000 NOP, 001 CLR, 010 SET, 011 CMP, 100 LD; 101-111 are NOP.
REQ-009 SHALL have port op_din, input, 1 bit: data for LD.
REQ-010 SHALL have ports set_vec and clr_vec, inputs, NFLAGS bits each: direct per-flag set and clear requests.
REQ-011 SHALL have ports push and pop, inputs, 1 bit each: save the flag vector to the stack, or restore it from the stack.
REQ-012 SHALL have port flags, output, NFLAGS bits: current flag values.
REQ-013 SHALL have port changed, output, NFLAGS bits: one-cycle pulse on each flag that toggled on the last edge.
REQ-014 SHALL have ports stk_cnt (output, $clog2(DEPTH+1) bits), stk_full and stk_empty (outputs, 1 bit): stack occupancy.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse on overflow, underflow, or an illegal op_sel.

Function
REQ-016 SHALL compute the next value of each flag by priority, highest first: RST, clr_vec[i], set_vec[i], pop restore, then op.
REQ-017 SHALL apply op only when op_valid=1 and op_sel=i: CLR gives 0, SET gives 1, CMP gives ~flag, LD gives op_din.
REQ-018 SHALL, when op_sel>=NFLAGS, ignore the op and pulse err on the next cycle.
REQ-019 SHALL, on a successful pop, replace the whole flag vector with the top entry; clr_vec and set_vec still override individual bits.
REQ-020 SHALL, on a push, capture the pre-edge flags value (not the post-update value).
REQ-021 SHALL give updates a latency of one clock: flags reflects a command on the edge that samples it.
REQ-022 SHALL ignore a push when stk_full and pulse err; the stack is unchanged and flag updates proceed.
REQ-023 SHALL ignore a pop when stk_empty and pulse err; the pop has no effect and the op path applies.
REQ-024 SHALL, on push and pop in the same cycle while not empty, perform the pop restore and overwrite the top entry with the pre-edge flags; stk_cnt is unchanged.
REQ-025 SHALL, on push and pop in the same cycle while empty, treat the request as a push only, with no err.
REQ-026 SHALL register changed as flags_next XOR flags; changed is 0 in the cycle after RST.
REQ-027 SHALL drive stk_full = (stk_cnt==DEPTH) and stk_empty = (stk_cnt==0), combinationally from stk_cnt.

Reset
REQ-028 SHALL, on RST, set flags=RST_VAL, stk_cnt=0, changed=0 and err=0; the stack contents are don't-care.
REQ-029 SHALL let RST override every concurrent input, including a push or pop in progress.
REQ-030 SHALL also load flags=RST_VAL at time zero for simulation.

Configuration
REQ-031 SHALL, with macro FLAG_BANK_STACK_EN defined, implement the stack of REQ-011, REQ-014 and REQ-019 to REQ-025.
REQ-032 SHALL, without FLAG_BANK_STACK_EN, ignore push and pop, tie stk_cnt=0, stk_empty=1 and stk_full=0, and never pulse err for stack events.

Structure
REQ-033 SHALL place the op_code encodings (FB_NOP, FB_CLR, FB_SET, FB_CMP, FB_LD) in the shared package flag_bank_pkg.
REQ-034 SHALL implement the stack as the sub-module flag_stack, parameterised by width NFLAGS and DEPTH, with push, pop, replace, top, cnt, full and empty.

Verification
REQ-035 SHALL cover: RST with RST_VAL=4'b1001, then idle -> flags=1001, stk_empty=1, changed=0000.
REQ-036 SHALL cover: op CMP on sel 2 issued twice from 0000 -> flags 0100, then 0000; changed=0100 on each edge.
REQ-037 SHALL cover: same cycle op SET on sel 1, clr_vec=0010, set_vec=0001 -> flags=0001 (clear beats op, set applies).
REQ-038 SHALL cover: flags=1010, push, then op LD 1 on sel 0, then pop -> flags 1011, then 1010; stk_cnt 1, then 0.
REQ-039 SHALL cover: DEPTH=2, three pushes -> stk_cnt=2, stk_full=1, err pulses on the third; then three pops -> err pulses on the third, stk_empty=1.
REQ-040 SHALL cover: RST asserted in the same cycle as a pop with stk_cnt=1 -> flags=RST_VAL, stk_cnt=0, err=0.

Source files
------------

// File: rtl/flag_bank_pkg.sv
// Shared definitions for the flag bank: op_code encodings and the per-flag op helper.
package flag_bank_pkg;

    localparam logic [2:0] FB_NOP = 3'b000;
    localparam logic [2:0] FB_CLR = 3'b001;
    localparam logic [2:0] FB_SET = 3'b010;
    localparam logic [2:0] FB_CMP = 3'b011;
    localparam logic [2:0] FB_LD  = 3'b100;

    // Result of applying one op to a single flag; 101-111 behave as NOP.
    function automatic logic fb_apply(input logic [2:0] code, input logic cur, input logic din);
        case (code)
            FB_NOP:  return cur;
            FB_CLR:  return 1'b0;
            FB_SET:  return 1'b1;
            FB_CMP:  return ~cur;
            FB_LD:   return din;
            default: return cur;
        endcase
    endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of flag vectors used to save/restore the flag bank.
// push and pop are expected to be pre-qualified by the owner; replace overwrites the top
// entry in place without moving the count.
module flag_stack
    import flag_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNTW = $clog2(DEPTH + 1),
    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CNTW-1:0]  cnt,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNTW-1:0]  cnt_q;
    logic [IDXW-1:0]  top_idx;
    logic [IDXW-1:0]  wr_idx;

    // Top entry sits at cnt-1; a push writes the slot just above it.
    always_comb begin
        top_idx = IDXW'(cnt_q - 1'b1);
        wr_idx  = replace ? top_idx : IDXW'(cnt_q);
    end

    // Occupancy counter; replace leaves it alone.
    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (push && !full) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset term.
    always_ff @(posedge clk) begin
        if (!RST && ((push && !full) || (replace && !empty))) begin
            mem_q[wr_idx] <= din;
        end
    end

    assign top   = mem_q[top_idx];
    assign cnt   = cnt_q;
    assign full  = (cnt_q == CNTW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/flag_bank.sv
// Bank of single-bit status flags with per-flag ops, direct set/clear vectors and an
// optional save/restore stack.
// Build option: define FLAG_BANK_STACK_EN to include the flag stack; without it push/pop
// are ignored and the stack status outputs are tied to "empty".
module flag_bank
    import flag_bank_pkg::*;
#(
    parameter int unsigned       NFLAGS  = 4,
    parameter int unsigned       DEPTH   = 2,
    parameter logic [NFLAGS-1:0] RST_VAL = '0,
    localparam int unsigned SELW = (NFLAGS > 1) ? $clog2(NFLAGS) : 1,
    localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              op_valid,
    input  logic [SELW-1:0]   op_sel,
    input  logic [2:0]        op_code,
    input  logic              op_din,
    input  logic [NFLAGS-1:0] set_vec,
    input  logic [NFLAGS-1:0] clr_vec,
    input  logic              push,
    input  logic              pop,
    output logic [NFLAGS-1:0] flags,
    output logic [NFLAGS-1:0] changed,
    output logic [CNTW-1:0]   stk_cnt,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              err
);

    // Initialiser gives the reset value at time zero in simulation.
    logic [NFLAGS-1:0] flags_q = RST_VAL;
    logic [NFLAGS-1:0] changed_q;
    logic              err_q;
    logic [NFLAGS-1:0] flags_d;
    logic [NFLAGS-1:0] stk_top;
    logic              sel_bad;
    logic              pop_ok;
    logic              stk_err;

    assign sel_bad = op_valid && (32'(op_sel) >= NFLAGS);

`ifdef FLAG_BANK_STACK_EN
    logic stk_push;
    logic stk_pop;
    logic stk_replace;

    // Resolve push/pop: push+pop on a non-empty stack swaps the top entry; on an empty
    // stack it degrades to a plain push.
    always_comb begin
        pop_ok      = pop && !stk_empty;
        stk_replace = push && pop_ok;
        stk_push    = push && !pop_ok && !stk_full;
        stk_pop     = pop_ok && !push;
        stk_err     = (push && !pop_ok && stk_full) || (pop && !push && stk_empty);
    end

    flag_stack #(
        .WIDTH (NFLAGS),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .RST     (RST),
        .push    (stk_push),
        .pop     (stk_pop),
        .replace (stk_replace),
        .din     (flags_q),
        .top     (stk_top),
        .cnt     (stk_cnt),
        .full    (stk_full),
        .empty   (stk_empty)
    );
`else
    logic unused_stack;

    assign unused_stack = ^{push, pop};
    assign pop_ok       = 1'b0;
    assign stk_err      = 1'b0;
    assign stk_top      = '0;
    assign stk_cnt      = '0;
    assign stk_full     = 1'b0;
    assign stk_empty    = 1'b1;
`endif

    // Next flags, lowest priority first: op, stack restore, set_vec, clr_vec.
    always_comb begin
        flags_d = flags_q;
        for (int i = 0; i < NFLAGS; i++) begin
            if (op_valid && !sel_bad && (32'(op_sel) == i)) begin
                flags_d[i] = fb_apply(op_code, flags_q[i], op_din);
            end
        end
        if (pop_ok) begin
            flags_d = stk_top;
        end
        flags_d = (flags_d | set_vec) & ~clr_vec;
    end

    // Flag state plus registered change and error pulses; reset beats everything.
    always_ff @(posedge clk) begin
        if (RST) begin
            flags_q   <= RST_VAL;
            changed_q <= '0;
            err_q     <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            changed_q <= flags_d ^ flags_q;
            err_q     <= sel_bad || stk_err;
        end
    end

    assign flags   = flags_q;
    assign changed = changed_q;
    assign err     = err_q;

endmodule
